// File: rtl/helio_pkg.sv
// -----------------------------------------------------------------------------
// helio_pkg
// Shared HelioSmart definitions: default servo code width, lux width, the sweep
// controller state encoding, the mode codes produced by the mode FSM, and a
// couple of constant helpers used to size delay counters.
// -----------------------------------------------------------------------------
package helio_pkg;

  localparam int POS_W = 8;
  localparam int LUX_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVE   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_REQ    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_PARK   = 3'd5,
    ST_HOLD   = 3'd6
  } sweep_state_t;

  typedef enum logic [1:0] {
    MODE_STANDBY = 2'd0,
    MODE_AUTO    = 2'd1,
    MODE_MANUAL  = 2'd2
  } mode_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/helio_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// helio_sweep_ctrl_if
// Measurement handshake between the sweep controller and the BH1750 driver.
//   lux_str  : one-cycle start pulse, controller -> driver
//   lux_busy : driver busy flag, driver -> controller
//   lux_data : measurement result, valid when lux_busy falls
// Modports: master = sweep controller, slave = BH1750 driver.
// -----------------------------------------------------------------------------
interface helio_sweep_ctrl_if;
  import helio_pkg::*;

  logic             lux_str;
  logic             lux_busy;
  logic [LUX_W-1:0] lux_data;

  modport master (output lux_str, input lux_busy, input lux_data);
  modport slave  (input lux_str, output lux_busy, output lux_data);
endinterface

// File: rtl/helio_ms_tick.sv
// -----------------------------------------------------------------------------
// helio_ms_tick
// Free-running prescaler: one-cycle tick every CLK_HZ/1000 clock cycles.
// Shared by the HelioSmart timers.
// Ports:
//   clk  : system clock
//   _rst : asynchronous active-low reset
//   tick : one-cycle pulse once per millisecond
// -----------------------------------------------------------------------------
module helio_ms_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic _rst,
  output logic tick
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/helio_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// helio_sweep_ctrl
// Sun-seeking sweep controller (auto mode). Steps the servo target across
// 0, STEP, 2*STEP ... <= POS_MAX, takes one BH1750 measurement per step after a
// settle delay, then parks at the brightest position (first maximum wins) and
// waits REFRESH_MS before re-sweeping. en low or abort high drops any sweep in
// progress back to IDLE while keeping pos and best_lux.
//
// Optional feature: define HELIO_LUX_TIMEOUT_EN to bound each measurement by
// TIMEOUT_MS; an expired measurement counts as 0 lux and sets sticky lux_err.
// Without it, WAIT waits indefinitely and lux_err stays 0.
//
// Ports:
//   clk, _rst  : clock, asynchronous active-low reset
//   en         : auto mode active
//   abort      : abort request (level)
//   lux        : BH1750 handshake (helio_sweep_ctrl_if.master)
//   pos        : servo target code
//   best_lux   : peak illuminance of the last completed sweep
//   sweeping   : high in MOVE/SETTLE/REQ/WAIT
//   done       : one-cycle pulse while parking
//   lux_err    : sticky measurement-timeout flag, cleared on sweep start
// -----------------------------------------------------------------------------
module helio_sweep_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int POS_W      = 8,
  parameter int POS_MAX    = 180,
  parameter int STEP       = 15,
  parameter int SETTLE_MS  = 200,
  parameter int TIMEOUT_MS = 300,
  parameter int REFRESH_MS = 60_000
) (
  input  logic                        clk,
  input  logic                        _rst,
  input  logic                        en,
  input  logic                        abort,
  helio_sweep_ctrl_if.master          lux,
  output logic [POS_W-1:0]            pos,
  output logic [helio_pkg::LUX_W-1:0] best_lux,
  output logic                        sweeping,
  output logic                        done,
  output logic                        lux_err
);
  import helio_pkg::*;

  localparam int CNT_W = cnt_width(max3(SETTLE_MS, TIMEOUT_MS, REFRESH_MS));
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_MS);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] REFRESH_LD = CNT_W'(REFRESH_MS);
  // One extra bit so k + STEP can exceed the code range without wrapping.
  localparam logic [POS_W:0]   POS_MAX_X  = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0]   STEP_X     = (POS_W+1)'(STEP);

  sweep_state_t state, state_next;

  logic [POS_W-1:0] k, k_next;
  logic [POS_W-1:0] best_pos, best_pos_next;
  logic [POS_W-1:0] pos_next;
  logic [LUX_W-1:0] cur_best, cur_best_next;
  logic [LUX_W-1:0] best_lux_next;
  logic [CNT_W-1:0] dly_cnt, dly_cnt_next;
  logic             seen_busy, seen_busy_next;
  logic             err_q, err_next;

  logic             tick;
  logic             stop_req;
  logic             meas_done;
  logic [LUX_W-1:0] sample;
  logic [POS_W:0]   k_sum;

  helio_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk  (clk),
    ._rst (_rst),
    .tick (tick)
  );

  assign stop_req = !en || abort;
  assign k_sum    = {1'b0, k} + STEP_X;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      k         <= '0;
      best_pos  <= '0;
      cur_best  <= '0;
      pos       <= '0;
      best_lux  <= '0;
      dly_cnt   <= '0;
      seen_busy <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      k         <= k_next;
      best_pos  <= best_pos_next;
      cur_best  <= cur_best_next;
      pos       <= pos_next;
      best_lux  <= best_lux_next;
      dly_cnt   <= dly_cnt_next;
      seen_busy <= seen_busy_next;
      err_q     <= err_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    k_next         = k;
    best_pos_next  = best_pos;
    cur_best_next  = cur_best;
    pos_next       = pos;
    best_lux_next  = best_lux;
    dly_cnt_next   = dly_cnt;
    seen_busy_next = seen_busy;
    err_next       = err_q;
    meas_done      = 1'b0;
    sample         = '0;

    if (state != ST_IDLE && stop_req) begin
      // Discard the sweep; outputs hold whatever they showed.
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (en && !abort) begin
            state_next    = ST_MOVE;
            k_next        = '0;
            pos_next      = '0;
            cur_best_next = '0;
            best_pos_next = '0;
            err_next      = 1'b0;
          end
        end

        ST_MOVE: begin
          dly_cnt_next = SETTLE_LD;
          state_next   = ST_SETTLE;
        end

        ST_SETTLE: begin
          if (dly_cnt == '0)  state_next   = ST_REQ;
          else if (tick)      dly_cnt_next = dly_cnt - CNT_W'(1);
        end

        ST_REQ: begin
          // lux_str is high in this cycle exactly when this branch is taken.
          if (!lux.lux_busy) begin
            state_next     = ST_WAIT;
            seen_busy_next = 1'b0;
            dly_cnt_next   = TIMEOUT_LD;
          end
        end

        ST_WAIT: begin
          if (!seen_busy) begin
            if (lux.lux_busy) seen_busy_next = 1'b1;
          end else if (!lux.lux_busy) begin
            meas_done = 1'b1;
            sample    = lux.lux_data;
          end
`ifdef HELIO_LUX_TIMEOUT_EN
          if (!meas_done) begin
            if (dly_cnt == '0) begin
              meas_done = 1'b1;
              sample    = '0;
              err_next  = 1'b1;
            end else if (tick) begin
              dly_cnt_next = dly_cnt - CNT_W'(1);
            end
          end
`endif
          if (meas_done) begin
            if (sample > cur_best) begin
              cur_best_next = sample;
              best_pos_next = k;
            end
            if (k_sum <= POS_MAX_X) begin
              k_next     = k_sum[POS_W-1:0];
              pos_next   = k_sum[POS_W-1:0];
              state_next = ST_MOVE;
            end else begin
              // Park target and result become visible together with done.
              pos_next      = best_pos_next;
              best_lux_next = cur_best_next;
              state_next    = ST_PARK;
            end
          end
        end

        ST_PARK: begin
          dly_cnt_next = REFRESH_LD;
          state_next   = ST_HOLD;
        end

        ST_HOLD: begin
          if (dly_cnt == '0)  state_next   = ST_IDLE;
          else if (tick)      dly_cnt_next = dly_cnt - CNT_W'(1);
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Mealy start pulse: gated by busy so it can never fire into a busy driver,
  // and by stop_req so an abort in REQ issues no request.
  assign lux.lux_str = (state == ST_REQ) && !lux.lux_busy && !stop_req;

  assign sweeping = (state == ST_MOVE) || (state == ST_SETTLE) ||
                    (state == ST_REQ)  || (state == ST_WAIT);
  assign done     = (state == ST_PARK);
  assign lux_err  = err_q;

endmodule

// File: tb/tb_helio_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_helio_sweep_ctrl
// Directed bench for helio_sweep_ctrl. A table of full sweeps (per-step lux,
// dead-sensor mask, expected park position / peak / error flag) is applied in a
// loop, followed by hand-written sequences for abort, reset in WAIT, automatic
// re-sweep after HOLD and a driver that is busy when the request is due.
// BH1750 model: busy rises 3 cycles after lux_str and stays high 10 cycles.
// -----------------------------------------------------------------------------
module tb_helio_sweep_ctrl;
  import helio_pkg::*;

  localparam int CLK_HZ     = 10_000;
  localparam int POS_MAX    = 64;
  localparam int STEP       = 16;
  localparam int SETTLE_MS  = 2;
  localparam int TIMEOUT_MS = 5;
  localparam int REFRESH_MS = 20;
  localparam int NSTEP      = 5;

`ifdef HELIO_LUX_TIMEOUT_EN
  localparam int  NV      = 6;
  localparam logic TO_ERR = 1'b1;
`else
  localparam int  NV      = 5;
  localparam logic TO_ERR = 1'b0;
`endif

  typedef struct {
    logic [NSTEP-1:0][15:0] lux;
    logic [NSTEP-1:0]       dead;
    logic [7:0]             exp_pos;
    logic [15:0]            exp_best;
    logic                   exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  pos;
  logic [15:0] best_lux;
  logic        sweeping, done, lux_err;

  helio_sweep_ctrl_if sif();

  helio_sweep_ctrl #(
    .CLK_HZ(CLK_HZ), .POS_W(8), .POS_MAX(POS_MAX), .STEP(STEP),
    .SETTLE_MS(SETTLE_MS), .TIMEOUT_MS(TIMEOUT_MS), .REFRESH_MS(REFRESH_MS)
  ) dut (
    .clk      (clk),
    ._rst     (rst_n),
    .en       (en),
    .abort    (abort),
    .lux      (sif),
    .pos      (pos),
    .best_lux (best_lux),
    .sweeping (sweeping),
    .done     (done),
    .lux_err  (lux_err)
  );

  always #5 clk = ~clk;

  // ---------------- BH1750 model and monitors (negedge) ----------------
  logic [NSTEP-1:0][15:0] mdl_lux;
  logic [NSTEP-1:0]       mdl_dead;
  logic                   mdl_busy = 1'b0;
  logic                   force_busy = 1'b0;
  logic [15:0]            mdl_data = '0;
  int                     mdl_cnt = 0;
  int                     mdl_idx = 0;
  logic [7:0]             pos_log [NSTEP];
  int                     str_cnt = 0;
  int                     done_cnt = 0;
  int                     proto_err = 0;
  logic                   prev_str = 1'b0;

  assign sif.lux_busy = mdl_busy | force_busy;
  assign sif.lux_data = mdl_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_cnt  = 0;
      mdl_busy = 1'b0;
      prev_str = 1'b0;
    end else begin
      if (sif.lux_str) begin
        str_cnt++;
        if (prev_str || sif.lux_busy) proto_err++;
        if (mdl_idx < NSTEP) pos_log[mdl_idx] = pos;
      end
      prev_str = sif.lux_str;
      if (done) done_cnt++;
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        mdl_busy = (mdl_cnt >= 1 && mdl_cnt <= 10);
      end else if (prev_str) begin
        if (mdl_idx < NSTEP && !mdl_dead[mdl_idx]) begin
          mdl_cnt  = 13;
          mdl_data = mdl_lux[mdl_idx];
        end
        mdl_idx++;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic load_model(input logic [NSTEP-1:0][15:0] l, input logic [NSTEP-1:0] d);
    mdl_lux  = l;
    mdl_dead = d;
    mdl_idx  = 0;
    for (int j = 0; j < NSTEP; j++) pos_log[j] = 8'hFF;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, " done seen"}, 32'(done), 1);
  endtask

  function automatic vec_t mk(input int l0, input int l1, input int l2, input int l3,
                              input int l4, input logic [NSTEP-1:0] dead,
                              input int p, input int b, input logic e);
    vec_t v;
    v.lux[0] = 16'(l0); v.lux[1] = 16'(l1); v.lux[2] = 16'(l2);
    v.lux[3] = 16'(l3); v.lux[4] = 16'(l4);
    v.dead = dead; v.exp_pos = 8'(p); v.exp_best = 16'(b); v.exp_err = e;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    vec_t vecs [NV];
    logic [NSTEP-1:0][15:0] l;
    int s0, d0, c;
    logic [15:0] prior_best;

    vecs[0] = mk(10, 50, 90, 90, 20, 5'b00000, 32, 90, 1'b0);
    vecs[1] = mk(5, 5, 5, 5, 5, 5'b00000, 0, 5, 1'b0);
    vecs[2] = mk(0, 0, 0, 0, 0, 5'b00000, 0, 0, 1'b0);
    vecs[3] = mk(7, 3, 1, 2, 100, 5'b00000, 64, 100, 1'b0);
    vecs[4] = mk(65535, 0, 0, 0, 65535, 5'b00000, 0, 65535, 1'b0);
`ifdef HELIO_LUX_TIMEOUT_EN
    vecs[5] = mk(10, 99, 30, 40, 20, 5'b00010, 48, 40, 1'b1);
`endif

    // Reset values
    mdl_dead = '0;
    mdl_lux  = '0;
    repeat (3) @(negedge clk);
    check("rst pos", 32'(pos), 0);
    check("rst best_lux", 32'(best_lux), 0);
    check("rst sweeping", 32'(sweeping), 0);
    check("rst done", 32'(done), 0);
    check("rst lux_str", 32'(sif.lux_str), 0);
    check("rst lux_err", 32'(lux_err), 0);
    drive_slot();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle en=0 sweeping", 32'(sweeping), 0);

    // Table of full sweeps
    for (int i = 0; i < NV; i++) begin
      drive_slot();
      load_model(vecs[i].lux, vecs[i].dead);
      s0 = str_cnt;
      d0 = done_cnt;
      en = 1'b1;
      wait_done(2000, "vec");
      check("vec park pos", 32'(pos), 32'(vecs[i].exp_pos));
      check("vec best_lux", 32'(best_lux), 32'(vecs[i].exp_best));
      check("vec lux_err", 32'(lux_err), 32'(vecs[i].exp_err));
      for (int j = 0; j < NSTEP; j++) check("vec visit pos", 32'(pos_log[j]), 32'(j * STEP));
      drive_slot();
      en = 1'b0;
      repeat (3) @(negedge clk);
      check("vec lux_str count", 32'(str_cnt - s0), 5);
      check("vec done count", 32'(done_cnt - d0), 1);
      check("vec back to idle", 32'(sweeping), 0);
    end
    prior_best = vecs[NV-1].exp_best;

    // Abort during SETTLE of step 3
    drive_slot();
    l = '{default: 16'd1};
    load_model(l, '0);
    s0 = str_cnt;
    d0 = done_cnt;
    en = 1'b1;
    c = 0;
    while (!(sweeping && pos == 8'd32) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("abort reach step3", 32'(pos), 32);
    repeat (2) @(negedge clk);
    drive_slot();
    abort = 1'b1;
    @(negedge clk);
    check("abort same cycle sweeping", 32'(sweeping), 1);
    @(negedge clk);
    check("abort next cycle idle", 32'(sweeping), 0);
    repeat (100) @(negedge clk);
    check("abort lux_str count", 32'(str_cnt - s0), 2);
    check("abort pos held", 32'(pos), 32);
    check("abort best_lux held", 32'(best_lux), 32'(prior_best));
    check("abort no done", 32'(done_cnt - d0), 0);
    drive_slot();
    abort = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset asserted in WAIT of step 2, then a fresh sweep
    drive_slot();
    load_model(vecs[0].lux, {TO_ERR, 4'b0000});
    en = 1'b1;
    c = 0;
    while (!(mdl_busy && pos == 8'd16) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("rst-wait reach step2", 32'(pos), 16);
    drive_slot();
    rst_n = 1'b0;
    #1;
    check("rst-wait pos", 32'(pos), 0);
    check("rst-wait best_lux", 32'(best_lux), 0);
    check("rst-wait sweeping", 32'(sweeping), 0);
    check("rst-wait done", 32'(done), 0);
    check("rst-wait lux_str", 32'(sif.lux_str), 0);
    check("rst-wait lux_err", 32'(lux_err), 0);
    repeat (3) @(negedge clk);
    drive_slot();
    load_model(vecs[0].lux, {TO_ERR, 4'b0000});
    s0 = str_cnt;
    rst_n = 1'b1;
    wait_done(2000, "rst-wait resweep");
    check("rst-wait first pos", 32'(pos_log[0]), 0);
    check("rst-wait park pos", 32'(pos), 32);
    check("rst-wait best", 32'(best_lux), 90);
    check("rst-wait lux_err", 32'(lux_err), 32'(TO_ERR));

    // Automatic re-sweep after HOLD with en held high
    drive_slot();
    l = '{default: 16'd5};
    load_model(l, '0);
    s0 = str_cnt;
    c = 0;
    while (!sweeping && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("hold length in range", 32'(c >= 185 && c <= 210), 1);
    check("resweep lux_err cleared", 32'(lux_err), 0);
    wait_done(2000, "resweep");
    check("resweep park pos", 32'(pos), 0);
    check("resweep best", 32'(best_lux), 5);
    drive_slot();
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("resweep lux_str count", 32'(str_cnt - s0), 5);

    // Driver busy when the request is due
    drive_slot();
    load_model(vecs[0].lux, '0);
    force_busy = 1'b1;
    s0 = str_cnt;
    en = 1'b1;
    repeat (80) @(negedge clk);
    check("busy-hold no lux_str", 32'(str_cnt - s0), 0);
    check("busy-hold still sweeping", 32'(sweeping), 1);
    check("busy-hold at pos 0", 32'(pos), 0);
    drive_slot();
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("busy-hold one lux_str", 32'(str_cnt - s0), 1);
    wait_done(2000, "busy-hold");
    check("busy-hold park pos", 32'(pos), 32);
    check("busy-hold best", 32'(best_lux), 90);
    drive_slot();
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("busy-hold lux_str count", 32'(str_cnt - s0), 5);

    check("lux_str protocol violations", 32'(proto_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/helio_sweep_ctrl.md
# helio_sweep_ctrl

Sun-seeking sweep controller for the HelioSmart tracker in automatic mode. It sequences the servo PWM target and the BH1750 light-sensor measurement handshake. It steps the panel across its angular range and samples illuminance at each step, then parks the panel at the brightest position. It re-sweeps periodically and sits between the mode FSM (auto mode / abort key), the BH1750 driver and the PWM servo driver.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency; sets the 1 ms tick prescaler (CLK_HZ/1000 cycles).
- POS_W, 8, width of the servo position code.
- POS_MAX, 180, highest legal position code.
- STEP, 15, position increment per sweep step; must be ≥1.
- SETTLE_MS, 200, servo settle time before each measurement.
- TIMEOUT_MS, 300, maximum wait for a sensor measurement.
- REFRESH_MS, 60_000, idle time in HOLD before an automatic re-sweep.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- _rst  in  1  asynchronous, active-low reset.
- en  in  1  high while the mode FSM is in auto mode.
- abort  in  1  abort request (key F); level, sampled each clk.
- lux_busy  in  1  BH1750 driver busy flag.
- lux_data  in  16  BH1750 result; valid when busy falls.
- lux_str  out  1  one-cycle measurement start pulse to the BH1750 driver.
- pos  out  POS_W  servo target code to the PWM driver.
- best_lux  out  16  maximum illuminance of the last completed sweep.
- sweeping  out  1  high during MOVE/SETTLE/REQ/WAIT.
- done  out  1  one-cycle pulse when a sweep completes and the panel parks.
- lux_err  out  1  sticky; set on measurement timeout, cleared by reset or a new sweep start.

## Operation
- States: IDLE, MOVE, SETTLE, REQ, WAIT, PARK, HOLD.
- IDLE: on en=1 and abort=0, clear cur_best/best_pos_tmp, clear lux_err, set step position k=0, go to MOVE.
- MOVE: pos←k; load settle counter; go to SETTLE.
- SETTLE: count SETTLE_MS ms ticks, then go to REQ.
- REQ: wait for lux_busy=0, then assert lux_str for exactly one cycle and go to WAIT.
- WAIT: first wait for lux_busy=1, then for lux_busy=0. On the falling edge, sample=lux_data.
- Comparison: if sample > cur_best (strict; first maximum wins), record cur_best=sample and best_pos_tmp=k.
- Next step: if k+STEP ≤ POS_MAX, set k←k+STEP and go to MOVE; else go to PARK. Compute k+STEP at POS_W+1 bits so no wrap-around occurs. Positions visited: 0, STEP, 2·STEP… up to the largest multiple ≤ POS_MAX.
- PARK: pos←best_pos_tmp, best_lux←cur_best, done=1 for one cycle, go to HOLD.
- HOLD: count REFRESH_MS, then go to IDLE, which immediately re-sweeps if en is still high.
- en=0 or abort=1 in any non-IDLE state: go to IDLE next cycle, no lux_str. pos and best_lux keep their values. A sweep in progress is discarded.
- All-zero sweep: best position is 0 and best_lux is 0.

## Timing
- Reset values: pos=0, best_lux=0, lux_str=0, sweeping=0, done=0, lux_err=0, state=IDLE, all counters 0.
- The ms tick is free-running. Delay counters count ticks, so the first delay may fall short of a full ms by up to one ms.
- IDLE→MOVE: 1 cycle. MOVE→SETTLE: 1 cycle. pos updates in the MOVE cycle.
- lux_str is never high two cycles in a row and never asserted while lux_busy=1.
- Capture happens in the cycle lux_busy is first seen low after being high.
- done rises on the cycle after the final capture. pos=best position in that same cycle.
- Reset asserted mid-sweep: all outputs return to reset values asynchronously.

## Configuration
- HELIO_LUX_TIMEOUT_EN defined: WAIT runs a TIMEOUT_MS counter. On expiry, the sample is taken as 0, lux_err is set, and the sweep continues to the next step.
- HELIO_LUX_TIMEOUT_EN undefined: WAIT waits indefinitely, and lux_err is tied to 0.

## Structure
- Shared package helio_pkg: state enum, POS_W, LUX_W=16, and the mode codes used by the mode FSM (standby/auto/manual).
- Sub-module helio_ms_tick: prescaler producing a one-cycle pulse every CLK_HZ/1000 cycles. It is reused by the other HelioSmart timers.

## Test plan
Bench parameters: CLK_HZ=10_000, POS_MAX=64, STEP=16, SETTLE_MS=2, TIMEOUT_MS=5, REFRESH_MS=20. A BH1750 model asserts busy 3 cycles after str for 10 cycles.
- Lux per step [10,50,90,90,20], en=1 → positions 0,16,32,48,64 visited; final pos=32, best_lux=90, one done pulse, exactly 5 lux_str pulses.
- Abort high during step 3 SETTLE → IDLE next cycle, no further lux_str; pos stays 32 and best_lux stays at its prior value.
- Model never raises busy (timeout build) → after 5 ms, lux_err=1 and the sweep completes; best_lux is the max of the remaining samples.
- _rst low during WAIT → all outputs 0 immediately. After release with en=1, a fresh sweep starts at pos=0.
- HOLD with en=1 for 20 ms → a second sweep starts automatically and lux_err clears. A second sweep with lux [5,5,5,5,5] → pos=0, best_lux=5.
- lux_busy held high at REQ entry → lux_str deferred until busy drops, then pulses once.
